pcq_clks_pm_seq: RTL and testbench

- Power-management thold/flush sequencer, directly upstream of the clock-control stage; drives its ct_ck_pm_raise_tholds and ct_ck_pm_ccflush_disable inputs.
- Converts a level sleep request from core power management into an ordered sequence: raise run tholds, wait, disable ccflush, acknowledge; the reverse order on wake.
- Holds both outputs inactive whenever test/LBIST is active or clock control is disabled.

---
 rtl/pcq_pm_pkg.sv | 18 +
 rtl/pcq_pm_dly_cnt.sv | 27 ++
 rtl/pcq_clks_pm_seq.sv | 111 +++++++++++
 tb/tb_pcq_clks_pm_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcq_pm_pkg.sv
// Shared definitions for the power-management thold/flush sequencer:
// state encodings and default delay/counter sizes.
package pcq_pm_pkg;

   localparam int STATE_W        = 3;
   localparam int DEF_RAISE_DLY  = 8;
   localparam int DEF_LOWER_DLY  = 8;
   localparam int DEF_DLY_WIDTH  = 4;
   localparam int DEF_SCNT_WIDTH = 16;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'b000,
      RAISE = 3'b001,
      SLEEP = 3'b010,
      WAKE  = 3'b011
   } pm_state_e;

endpackage

// File: rtl/pcq_pm_dly_cnt.sv
// Loadable down-counter that parks at zero; times the RAISE and WAKE phases.
module pcq_pm_dly_cnt #(
   parameter int DLY_WIDTH = 4
) (
   input  logic                 nclk,
   input  logic                 nrst,
   input  logic                 load,
   input  logic [DLY_WIDTH-1:0] load_val,
   output logic                 zero
);

   logic [DLY_WIDTH-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge nclk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - DLY_WIDTH'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pcq_clks_pm_seq.sv
// Power-management sequencer: turns a level sleep request into an ordered
// raise-tholds / disable-ccflush / ack sequence, reversed on wake.
module pcq_clks_pm_seq
   import pcq_pm_pkg::*;
#(
   parameter int RAISE_DLY  = DEF_RAISE_DLY,
   parameter int LOWER_DLY  = DEF_LOWER_DLY,
   parameter int DLY_WIDTH  = DEF_DLY_WIDTH,
   parameter int SCNT_WIDTH = DEF_SCNT_WIDTH
) (
   input  logic                  nclk,
   input  logic                  nrst,
   input  logic                  pm_sleep_req,
   input  logic                  ccenable_dc,
   input  logic                  lbist_en_dc,
   input  logic                  gsd_test_enable_dc,
   output logic                  ct_ck_pm_raise_tholds,
   output logic                  ct_ck_pm_ccflush_disable,
   output logic                  pm_sleep_ack,
   output logic                  pm_wake_done,
   output logic [STATE_W-1:0]    pm_seq_state,
   output logic [SCNT_WIDTH-1:0] pm_sleep_cnt
);

   localparam logic [DLY_WIDTH-1:0] RAISE_LD = DLY_WIDTH'(RAISE_DLY - 1);
   localparam logic [DLY_WIDTH-1:0] LOWER_LD = DLY_WIDTH'(LOWER_DLY - 1);

   pm_state_e            state, state_nxt;
   logic                 force_idle;
   logic                 dly_load;
   logic [DLY_WIDTH-1:0] dly_load_val;
   logic                 dly_zero;
   logic                 cnt_clr;
   logic                 done_nxt;

   assign force_idle = lbist_en_dc | gsd_test_enable_dc | ~ccenable_dc;

   pcq_pm_dly_cnt #(
      .DLY_WIDTH (DLY_WIDTH)
   ) u_dly_cnt (
      .nclk     (nclk),
      .nrst     (nrst),
      .load     (dly_load),
      .load_val (dly_load_val),
      .zero     (dly_zero)
   );

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt    = state;
      dly_load     = 1'b0;
      dly_load_val = RAISE_LD;
      cnt_clr      = 1'b0;
      done_nxt     = 1'b0;
      if (force_idle) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (pm_sleep_req) begin
               state_nxt = RAISE;
               dly_load  = 1'b1;
               cnt_clr   = 1'b1;
            end
            // An abort outranks delay expiry: tholds stay up through a full WAKE.
            RAISE: if (!pm_sleep_req) begin
               state_nxt    = WAKE;
               dly_load     = 1'b1;
               dly_load_val = LOWER_LD;
            end else if (dly_zero) begin
               state_nxt = SLEEP;
            end
            SLEEP: if (!pm_sleep_req) begin
               state_nxt    = WAKE;
               dly_load     = 1'b1;
               dly_load_val = LOWER_LD;
            end
            WAKE: if (dly_zero) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with pm_seq_state.
   always_ff @(posedge nclk or negedge nrst) begin
      if (!nrst) begin
         state                    <= IDLE;
         ct_ck_pm_raise_tholds    <= 1'b0;
         ct_ck_pm_ccflush_disable <= 1'b0;
         pm_sleep_ack             <= 1'b0;
         pm_wake_done             <= 1'b0;
         pm_sleep_cnt             <= '0;
      end else begin
         state                    <= state_nxt;
         ct_ck_pm_raise_tholds    <= (state_nxt != IDLE);
         ct_ck_pm_ccflush_disable <= (state_nxt == SLEEP);
         pm_sleep_ack             <= (state_nxt == SLEEP);
         pm_wake_done             <= done_nxt;
         if (cnt_clr) begin
            pm_sleep_cnt <= '0;
         end else if (!force_idle && state == SLEEP && !(&pm_sleep_cnt)) begin
            pm_sleep_cnt <= pm_sleep_cnt + SCNT_WIDTH'(1);
         end
      end
   end

   assign pm_seq_state = state;

endmodule

// File: tb/tb_pcq_clks_pm_seq.sv
// Bench for pcq_clks_pm_seq: three instances (8/8, 8/8 with 4-bit sleep counter,
// 1/1) share stimulus; each is compared per cycle with a phase/timer model.
module tb_pcq_clks_pm_seq;

   logic nclk = 1'b0;
   logic nrst, req, ccen, lbist, gsd;
   always #5 nclk = ~nclk;

   logic [2:0]  st_a, st_s, st_b;
   logic        rz_a, rz_s, rz_b, ds_a, ds_s, ds_b, ak_a, ak_s, ak_b, dn_a, dn_s, dn_b;
   logic [15:0] cn_a, cn_b;
   logic [3:0]  cn_s;

   pcq_clks_pm_seq #(.RAISE_DLY(8), .LOWER_DLY(8), .DLY_WIDTH(4), .SCNT_WIDTH(16)) dut_a (
      .nclk(nclk), .nrst(nrst), .pm_sleep_req(req), .ccenable_dc(ccen), .lbist_en_dc(lbist),
      .gsd_test_enable_dc(gsd), .ct_ck_pm_raise_tholds(rz_a), .ct_ck_pm_ccflush_disable(ds_a),
      .pm_sleep_ack(ak_a), .pm_wake_done(dn_a), .pm_seq_state(st_a), .pm_sleep_cnt(cn_a));

   pcq_clks_pm_seq #(.RAISE_DLY(8), .LOWER_DLY(8), .DLY_WIDTH(4), .SCNT_WIDTH(4)) dut_s (
      .nclk(nclk), .nrst(nrst), .pm_sleep_req(req), .ccenable_dc(ccen), .lbist_en_dc(lbist),
      .gsd_test_enable_dc(gsd), .ct_ck_pm_raise_tholds(rz_s), .ct_ck_pm_ccflush_disable(ds_s),
      .pm_sleep_ack(ak_s), .pm_wake_done(dn_s), .pm_seq_state(st_s), .pm_sleep_cnt(cn_s));

   pcq_clks_pm_seq #(.RAISE_DLY(1), .LOWER_DLY(1), .DLY_WIDTH(4), .SCNT_WIDTH(16)) dut_b (
      .nclk(nclk), .nrst(nrst), .pm_sleep_req(req), .ccenable_dc(ccen), .lbist_en_dc(lbist),
      .gsd_test_enable_dc(gsd), .ct_ck_pm_raise_tholds(rz_b), .ct_ck_pm_ccflush_disable(ds_b),
      .pm_sleep_ack(ak_b), .pm_wake_done(dn_b), .pm_seq_state(st_b), .pm_sleep_cnt(cn_b));

   logic [2:0]  o_state [3];
   logic        o_raise [3], o_dis [3], o_ack [3], o_done [3];
   logic [15:0] o_cnt   [3];

   always_comb begin
      o_state[0] = st_a; o_state[1] = st_s; o_state[2] = st_b;
      o_raise[0] = rz_a; o_raise[1] = rz_s; o_raise[2] = rz_b;
      o_dis[0]   = ds_a; o_dis[1]   = ds_s; o_dis[2]   = ds_b;
      o_ack[0]   = ak_a; o_ack[1]   = ak_s; o_ack[2]   = ak_b;
      o_done[0]  = dn_a; o_done[1]  = dn_s; o_done[2]  = dn_b;
      o_cnt[0]   = cn_a; o_cnt[1]   = {12'd0, cn_s}; o_cnt[2] = cn_b;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase 0=idle 1=raising 2=asleep 3=waking; 'spent' counts whole
   // cycles already completed in the current phase.
   int m_rdly [3] = '{8, 8, 1};
   int m_ldly [3] = '{8, 8, 1};
   int m_cmax [3] = '{65535, 15, 65535};
   int m_phase [3], m_spent [3], m_cnt [3];
   bit m_done [3];
   bit prev_raise [3], prev_dis [3];

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_phase[i] = 0; m_spent[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
         prev_raise[i] = 0; prev_dis[i] = 0;
      end
   endtask

   task automatic model_step();
      bit blocked;
      blocked = lbist | gsd | ~ccen;
      for (int i = 0; i < 3; i++) begin
         if (!nrst) begin
            m_phase[i] = 0; m_spent[i] = 0; m_cnt[i] = 0; m_done[i] = 0;
         end else if (blocked) begin
            m_phase[i] = 0; m_spent[i] = 0; m_done[i] = 0;
         end else begin
            m_done[i] = 0;
            case (m_phase[i])
               0: if (req) begin m_phase[i] = 1; m_spent[i] = 0; m_cnt[i] = 0; end
               1: if (!req) begin m_phase[i] = 3; m_spent[i] = 0; end
                  else if (m_spent[i] + 1 == m_rdly[i]) begin m_phase[i] = 2; m_spent[i] = 0; end
                  else m_spent[i]++;
               2: begin
                  if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                  if (!req) begin m_phase[i] = 3; m_spent[i] = 0; end
               end
               default: if (m_spent[i] + 1 == m_ldly[i]) begin
                  m_phase[i] = 0; m_spent[i] = 0; m_done[i] = 1;
               end else m_spent[i]++;
            endcase
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d state", i), 32'(o_state[i]), 32'(m_phase[i]));
         check($sformatf("u%0d raise", i), 32'(o_raise[i]), 32'(m_phase[i] != 0));
         check($sformatf("u%0d disable", i), 32'(o_dis[i]), 32'(m_phase[i] == 2));
         check($sformatf("u%0d ack", i), 32'(o_ack[i]), 32'(m_phase[i] == 2));
         check($sformatf("u%0d done", i), 32'(o_done[i]), 32'(m_done[i]));
         check($sformatf("u%0d sleep_cnt", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
         if (o_dis[i] === 1'b1) begin
            check($sformatf("u%0d inv disable->raise", i), 32'(o_raise[i]), 32'd1);
            if (!prev_dis[i]) check($sformatf("u%0d inv disable rose with raise", i), 32'(prev_raise[i]), 32'd1);
         end
         prev_raise[i] = o_raise[i];
         prev_dis[i]   = o_dis[i];
      end
   endtask

   task automatic tick();
      @(posedge nclk);
      model_step();
      @(negedge nclk);
      compare_all();
   endtask

   typedef struct {
      bit req, lbist, gsd, ccen;
      int n;
      logic [2:0] st;
      bit raise, dis, ack, done;
      int cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit lb, input bit g, input bit ce, input int n,
                      input logic [2:0] st, input bit rz, input bit ds, input bit ak,
                      input bit dn, input int cnt);
      vec_t v;
      v.req = r; v.lbist = lb; v.gsd = g; v.ccen = ce; v.n = n;
      v.st = st; v.raise = rz; v.dis = ds; v.ack = ak; v.done = dn; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      // Expected values below are for the 8/8 instance.
      // Basic entry / exit
      add(1,0,0,1, 1, 3'd1, 1,0,0,0, 0);
      add(1,0,0,1, 7, 3'd1, 1,0,0,0, 0);
      add(1,0,0,1, 1, 3'd2, 1,1,1,0, 0);
      add(1,0,0,1,20, 3'd2, 1,1,1,0,20);
      add(0,0,0,1, 1, 3'd3, 1,0,0,0,21);
      add(0,0,0,1, 7, 3'd3, 1,0,0,0,21);
      add(0,0,0,1, 1, 3'd0, 0,0,0,1,21);
      add(0,0,0,1, 1, 3'd0, 0,0,0,0,21);
      // Abort after three RAISE cycles
      add(1,0,0,1, 3, 3'd1, 1,0,0,0, 0);
      add(0,0,0,1, 1, 3'd3, 1,0,0,0, 0);
      add(0,0,0,1, 7, 3'd3, 1,0,0,0, 0);
      add(0,0,0,1, 1, 3'd0, 0,0,0,1, 0);
      add(0,0,0,1, 2, 3'd0, 0,0,0,0, 0);
      // Force out of SLEEP: lbist, then ccenable low, then test enable
      add(1,0,0,1, 9, 3'd2, 1,1,1,0, 0);
      add(1,0,0,1, 5, 3'd2, 1,1,1,0, 5);
      add(1,1,0,1, 1, 3'd0, 0,0,0,0, 5);
      add(1,1,0,1, 3, 3'd0, 0,0,0,0, 5);
      add(1,0,0,1, 1, 3'd1, 1,0,0,0, 0);
      add(1,0,0,1, 8, 3'd2, 1,1,1,0, 0);
      add(1,0,0,1, 2, 3'd2, 1,1,1,0, 2);
      add(1,0,0,0, 1, 3'd0, 0,0,0,0, 2);
      add(1,0,0,1, 9, 3'd2, 1,1,1,0, 0);
      add(1,0,0,1, 3, 3'd2, 1,1,1,0, 3);
      add(1,0,1,1, 1, 3'd0, 0,0,0,0, 3);
      add(0,0,0,1, 2, 3'd0, 0,0,0,0, 3);

      nrst = 1'b0; req = 1'b0; ccen = 1'b1; lbist = 1'b0; gsd = 1'b0;
      model_reset();
      repeat (2) tick();
      nrst = 1'b1;
      tick();

      foreach (vecs[k]) begin
         req = vecs[k].req; lbist = vecs[k].lbist; gsd = vecs[k].gsd; ccen = vecs[k].ccen;
         repeat (vecs[k].n) tick();
         check($sformatf("vec%0d state", k), 32'(st_a), 32'(vecs[k].st));
         check($sformatf("vec%0d raise", k), 32'(rz_a), 32'(vecs[k].raise));
         check($sformatf("vec%0d disable", k), 32'(ds_a), 32'(vecs[k].dis));
         check($sformatf("vec%0d ack", k), 32'(ak_a), 32'(vecs[k].ack));
         check($sformatf("vec%0d done", k), 32'(dn_a), 32'(vecs[k].done));
         check($sformatf("vec%0d sleep_cnt", k), 32'(cn_a), 32'(vecs[k].cnt));
      end

      // Saturation of the 4-bit sleep counter, then clear on re-entry
      req = 1'b1;
      repeat (9) tick();
      repeat (30) tick();
      check("sat cnt reached", 32'(cn_s), 32'd15);
      tick();
      check("sat cnt held", 32'(cn_s), 32'd15);
      req = 1'b0;
      repeat (10) tick();
      req = 1'b1;
      tick();
      check("sat cnt cleared", 32'(cn_s), 32'd0);

      // Asynchronous reset while the 8/8 instance is in WAKE
      repeat (8) tick();
      req = 1'b0;
      repeat (2) tick();
      check("pre-reset in wake", 32'(st_a), 32'd3);
      #2 nrst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("async u%0d state", i), 32'(o_state[i]), 32'd0);
         check($sformatf("async u%0d outs", i),
               32'({o_raise[i], o_dis[i], o_ack[i], o_done[i]}), 32'd0);
         check($sformatf("async u%0d cnt", i), 32'(o_cnt[i]), 32'd0);
      end
      req = 1'b1;
      #1 nrst = 1'b1;
      tick();
      check("post-reset raise", 32'({st_a, rz_a}), 32'({3'd1, 1'b1}));

      // 1/1 boundary with back-to-back re-entry across the done cycle
      req = 1'b0;
      repeat (12) tick();
      req = 1'b1;
      tick();
      check("b1 raise", 32'(st_b), 32'd1);
      tick();
      check("b1 sleep", 32'({st_b, ds_b, ak_b}), 32'({3'd2, 1'b1, 1'b1}));
      req = 1'b0;
      tick();
      check("b1 wake", 32'({st_b, rz_b, ds_b}), 32'({3'd3, 1'b1, 1'b0}));
      req = 1'b1;
      tick();
      check("b1 idle done", 32'({st_b, rz_b, dn_b}), 32'({3'd0, 1'b0, 1'b1}));
      tick();
      check("b1 re-entry", 32'({st_b, rz_b, dn_b}), 32'({3'd1, 1'b1, 1'b0}));

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(7) == 0) req = ~req;
         lbist = ($urandom_range(79) == 0);
         gsd   = ($urandom_range(79) == 0);
         ccen  = ($urandom_range(79) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
